// File: rtl/sigmoid_pkg.sv
// Shared sizing defaults, sample type and FSM encoding for the sigmoid error-statistics stage.
package sigmoid_pkg;

   localparam int W_DEF      = 13;
   localparam int LOG2_N_DEF = 12;

   // U1.12 fixed point, LSB = 2^-12
   typedef logic [W_DEF-1:0] fx_u1_12_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } err_state_e;

endpackage

// File: rtl/sigmoid_abs_diff.sv
// Stage 1 of the error pipeline: registered |a - b| for W-bit unsigned operands.
module sigmoid_abs_diff
   import sigmoid_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] e_o
);

   logic [W:0]   diff;
   logic [W-1:0] e_d, e_q;

   // W+1-bit two's-complement difference; magnitude always fits in W bits
   assign diff = {1'b0, a_i} - {1'b0, b_i};
   assign e_d  = diff[W] ? W'(-diff) : diff[W-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  e_q <= '0;
      else if (en_i) e_q <= e_d;
   end

   assign e_o = e_q;

endmodule

// File: rtl/sigmoid_err_stats.sv
// Batch error statistics (sum/mean/max, optional MSE/variance) for sigmoid_taylor results.
// Define SIGMOID_ERR_SQ_EN to build the squared-error accumulator, mse and var_err.
module sigmoid_err_stats
   import sigmoid_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int LOG2_N = LOG2_N_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W-1:0]        f_x,
   input  logic [W-1:0]        golden,
   output logic                busy,
   output logic                done,
   output logic [W+LOG2_N-1:0] sum_err,
   output logic [W-1:0]        mean_err,
   output logic [W-1:0]        max_err,
   output logic [LOG2_N-1:0]   max_idx,
   output logic [2*W-1:0]      mse,
   output logic [2*W-1:0]      var_err
);

   localparam int SW = W + LOG2_N;

   err_state_e        state_q, state_d;
   logic [LOG2_N-1:0] cnt_q, s1_idx_q, idx_q;
   logic              s1_vld_q;
   logic [W-1:0]      e1;
   logic [SW-1:0]     sum_q;
   logic [W-1:0]      max_q, mean_q;
   logic              accept, last, clr, fin_ld;

   assign accept = in_valid && (state_q == ST_ACCUM);
   assign last   = accept && (cnt_q == '1);
   assign clr    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   sigmoid_abs_diff #(.W(W)) u_abs (
      .clk    (clk),
      .reset_n(reset_n),
      .en_i   (accept),
      .a_i    (f_x),
      .b_i    (golden),
      .e_o    (e1)
   );

   // Stage 1 bookkeeping: sample index and valid travel alongside |e|
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         s1_idx_q <= '0;
         s1_vld_q <= 1'b0;
      end else if (clr) begin
         cnt_q    <= '0;
         s1_vld_q <= 1'b0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            cnt_q    <= cnt_q + 1'b1;
            s1_idx_q <= cnt_q;
         end
      end
   end

   // Stage 2: sum and strict-greater max (ties keep the earlier index)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= '0;
         max_q <= '0;
         idx_q <= '0;
      end else if (clr) begin
         sum_q <= '0;
         max_q <= '0;
         idx_q <= '0;
      end else if (s1_vld_q) begin
         sum_q <= sum_q + SW'(e1);
         if (e1 > max_q) begin
            max_q <= e1;
            idx_q <= s1_idx_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    mean_q <= '0;
      else if (clr)    mean_q <= '0;
      else if (fin_ld) mean_q <= sum_q[SW-1 -: W];
   end

`ifdef SIGMOID_ERR_SQ_EN
   localparam int QW = 2*W + LOG2_N;

   logic [QW-1:0]  sq_q;
   logic [2*W-1:0] e_sq, mse_q, var_q, mean_sq;
   logic           fin_ph_q;

   assign e_sq    = (2*W)'(e1) * (2*W)'(e1);
   assign mean_sq = (2*W)'(mean_q) * (2*W)'(mean_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sq_q     <= '0;
         mse_q    <= '0;
         var_q    <= '0;
         fin_ph_q <= 1'b0;
      end else if (clr) begin
         sq_q     <= '0;
         mse_q    <= '0;
         var_q    <= '0;
         fin_ph_q <= 1'b0;
      end else begin
         if (s1_vld_q) sq_q <= sq_q + QW'(e_sq);
         if (fin_ld) begin
            mse_q    <= sq_q[QW-1 -: 2*W];
            fin_ph_q <= 1'b1;
         end
         // Second FINAL cycle: mean_q and mse_q are settled, floor effects can make the difference negative
         if (state_q == ST_FINAL && fin_ph_q)
            var_q <= (mse_q >= mean_sq) ? (mse_q - mean_sq) : '0;
      end
   end

   assign mse     = mse_q;
   assign var_err = var_q;
`else
   assign mse     = '0;
   assign var_err = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      fin_ld  = 1'b0;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_ACCUM;
         ST_ACCUM: if (last)  state_d = ST_FINAL;
         ST_FINAL: begin
            // Wait for the last sample to leave stage 1 before sampling the accumulators
            if (!s1_vld_q) begin
`ifdef SIGMOID_ERR_SQ_EN
               if (fin_ph_q) state_d = ST_DONE;
               else          fin_ld  = 1'b1;
`else
               fin_ld  = 1'b1;
               state_d = ST_DONE;
`endif
            end
         end
         ST_DONE:  if (start) state_d = ST_ACCUM;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign in_ready = (state_q == ST_ACCUM);
   assign busy     = (state_q == ST_ACCUM) || (state_q == ST_FINAL);
   assign done     = (state_q == ST_DONE);
   assign sum_err  = sum_q;
   assign mean_err = mean_q;
   assign max_err  = max_q;
   assign max_idx  = idx_q;

endmodule

// File: tb/tb_sigmoid_err_stats.sv
// Scoreboard bench: a 4-sample-batch instance and a full 4096-sample instance share clock and reset.
module tb_sigmoid_err_stats;

`ifdef SIGMOID_ERR_SQ_EN
   localparam bit SQ      = 1'b1;
   localparam int FIN_LAT = 4;
`else
   localparam bit SQ      = 1'b0;
   localparam int FIN_LAT = 3;
`endif

   typedef struct {
      logic [63:0] sum, mean, max, idx, mse, vr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sel = 1'b0, st = 1'b0, vl = 1'b0;
   logic [12:0] fx = '0, gd = '0;

   logic        s_rdy, s_busy, s_done, b_rdy, b_busy, b_done;
   logic [14:0] s_sum;
   logic [24:0] b_sum;
   logic [12:0] s_mean, s_max, b_mean, b_max;
   logic [1:0]  s_idx;
   logic [11:0] b_idx;
   logic [25:0] s_mse, s_var, b_mse, b_var;

   logic        o_rdy, o_busy, o_done;
   logic [63:0] o_sum, o_mean, o_max, o_idx, o_mse, o_var;

   exp_t sb[$];
   int   n_vec = 0, n_err = 0;
   logic [12:0] tp_fx [4] = '{13'h800, 13'h810, 13'h7F0, 13'h805};

   always #5 clk = ~clk;

   sigmoid_err_stats #(.W(13), .LOG2_N(2)) u_small (
      .clk(clk), .reset_n(reset_n), .start(st & ~sel), .in_valid(vl & ~sel), .in_ready(s_rdy),
      .f_x(fx), .golden(gd), .busy(s_busy), .done(s_done), .sum_err(s_sum), .mean_err(s_mean),
      .max_err(s_max), .max_idx(s_idx), .mse(s_mse), .var_err(s_var)
   );

   sigmoid_err_stats #(.W(13), .LOG2_N(12)) u_big (
      .clk(clk), .reset_n(reset_n), .start(st & sel), .in_valid(vl & sel), .in_ready(b_rdy),
      .f_x(fx), .golden(gd), .busy(b_busy), .done(b_done), .sum_err(b_sum), .mean_err(b_mean),
      .max_err(b_max), .max_idx(b_idx), .mse(b_mse), .var_err(b_var)
   );

   assign o_rdy  = sel ? b_rdy  : s_rdy;
   assign o_busy = sel ? b_busy : s_busy;
   assign o_done = sel ? b_done : s_done;
   assign o_sum  = sel ? 64'(b_sum)  : 64'(s_sum);
   assign o_mean = sel ? 64'(b_mean) : 64'(s_mean);
   assign o_max  = sel ? 64'(b_max)  : 64'(s_max);
   assign o_idx  = sel ? 64'(b_idx)  : 64'(s_idx);
   assign o_mse  = sel ? 64'(b_mse)  : 64'(s_mse);
   assign o_var  = sel ? 64'(b_var)  : 64'(s_var);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rdy"},  64'(o_rdy),  0);
      chk({tag, "_busy"}, 64'(o_busy), 0);
      chk({tag, "_done"}, 64'(o_done), 0);
      chk({tag, "_sum"},  o_sum,  0);
      chk({tag, "_mean"}, o_mean, 0);
      chk({tag, "_max"},  o_max,  0);
      chk({tag, "_idx"},  o_idx,  0);
      chk({tag, "_mse"},  o_mse,  0);
      chk({tag, "_var"},  o_var,  0);
   endtask

   task automatic next_pair(input int mode, input int idx);
      case (mode)
         0: begin fx = tp_fx[idx % 4]; gd = 13'h800; end
         1: begin fx = 13'($urandom_range(0, 8191)); gd = 13'($urandom_range(0, 8191)); end
         default: begin fx = 13'($urandom_range(0, 8191)); gd = fx; end
      endcase
   endtask

   // mode 0: fixed 4-sample pattern, 1: random pairs, 2: f_x == golden
   task automatic run_batch(input int mode, input bit toggle, input int abort_at);
      int L, n, acc, cyc, lat;
      bit rdy;
      logic [63:0] m_sum, m_sq, m_max, m_idx, d, mn, ms;
      exp_t e, g;
      L = sel ? 12 : 2;
      n = 1 << L;
      m_sum = 0; m_sq = 0; m_max = 0; m_idx = 0;
      acc = 0; cyc = 0;
      st = 1'b1;
      @(posedge clk); #1;
      st = 1'b0;
      chk("rdy_after_start", 64'(o_rdy), 1);
      chk("busy_after_start", 64'(o_busy), 1);
      next_pair(mode, 0);
      while (acc < n && cyc < 4*n + 50) begin
         if (abort_at != 0 && acc == abort_at) break;
         vl  = toggle ? ~cyc[0] : 1'b1;
         st  = toggle && (cyc % 3 == 2);
         rdy = o_rdy;
         @(posedge clk); #1;
         cyc++;
         st = 1'b0;
         if (vl && rdy) begin
            d = (fx > gd) ? 64'(fx - gd) : 64'(gd - fx);
            m_sum += d;
            m_sq  += d * d;
            if (d > m_max) begin m_max = d; m_idx = 64'(acc); end
            acc++;
            next_pair(mode, acc);
         end
      end
      vl = 1'b0;
      if (abort_at != 0) return;
      chk("accepts", 64'(acc), 64'(n));
      mn     = m_sum >> L;
      ms     = m_sq >> L;
      e.sum  = m_sum;
      e.mean = mn;
      e.max  = m_max;
      e.idx  = m_idx;
      e.mse  = SQ ? ms : 0;
      e.vr   = SQ ? ((ms >= mn*mn) ? ms - mn*mn : 0) : 0;
      sb.push_back(e);
      // One cycle after the last accept: FINAL, and a start here must be ignored
      lat = 1;
      chk("rdy_drop", 64'(o_rdy), 0);
      chk("busy_final", 64'(o_busy), 1);
      if (toggle) st = 1'b1;
      while (!o_done && lat < 20) begin
         @(posedge clk); #1;
         st = 1'b0;
         lat++;
      end
      st = 1'b0;
      chk("done_lat", 64'(lat), 64'(FIN_LAT));
      chk("busy_done", 64'(o_busy), 0);
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         g = sb.pop_front();
         chk("sum",  o_sum,  g.sum);
         chk("mean", o_mean, g.mean);
         chk("max",  o_max,  g.max);
         chk("idx",  o_idx,  g.idx);
         chk("mse",  o_mse,  g.mse);
         chk("var",  o_var,  g.vr);
         // Extra valid samples in DONE must not be taken
         repeat (3) begin
            vl = 1'b1;
            fx = 13'($urandom_range(1, 8191));
            gd = 13'h0;
            @(posedge clk); #1;
            chk("hold_rdy",  64'(o_rdy),  0);
            chk("hold_done", 64'(o_done), 1);
            chk("hold_sum",  o_sum, g.sum);
         end
         vl = 1'b0;
      end
   endtask

   task automatic chk_tp(input string tag);
      chk({tag, "_sum"},  o_sum,  64'h25);
      chk({tag, "_mean"}, o_mean, 64'h9);
      chk({tag, "_max"},  o_max,  64'h10);
      chk({tag, "_idx"},  o_idx,  64'h1);
      chk({tag, "_mse"},  o_mse,  SQ ? 64'd134 : 64'd0);
      chk({tag, "_var"},  o_var,  SQ ? 64'd53  : 64'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      sel = 1'b0; chk_zero("rst_small");
      sel = 1'b1; chk_zero("rst_big");
      sel = 1'b0;
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_batch(0, 1'b0, 0);
      chk_tp("tp");
      run_batch(0, 1'b1, 0);
      chk_tp("tp_toggle");
      repeat (3) run_batch(1, 1'b0, 0);
      run_batch(1, 1'b1, 0);

      sel = 1'b1;
      run_batch(2, 1'b0, 0);
      chk("sweep_sum", o_sum, 0);
      chk("sweep_max", o_max, 0);

      run_batch(1, 1'b0, 100);
      chk("mid_busy", 64'(o_busy), 1);
      reset_n = 1'b0;
      #2;
      chk_zero("midrst");
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_batch(1, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sigmoid_err_stats.md
# sigmoid_err_stats

Downstream statistics stage for the `sigmoid_taylor` datapath. Accepts one approximation result per handshake alongside its golden sigmoid value, both unsigned U1.12. It accumulates absolute error, maximum error with its sample index, and optionally squared error over a fixed batch of 2^LOG2_N samples. At batch end it presents mean and maximum error (and MSE/variance when enabled) in hardware, replacing floating-point post-processing in simulation.

## Interface
- `W`, 13: sample width; U1.12, LSB = 2^-12.
- `LOG2_N`, 12: batch size exponent; N = 4096 samples.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; clears accumulators and opens a batch.
- `in_valid` in 1: `f_x`/`golden` valid this cycle.
- `in_ready` out 1: high only in ACCUM; sample accepted when `in_valid && in_ready`.
- `f_x` in W: approximation under test (sigmoid_taylor output).
- `golden` in W: exact sigmoid, same format.
- `busy` out 1: high in ACCUM and FINAL.
- `done` out 1: high in DONE; results stable while high.
- `sum_err` out W+LOG2_N: Σ|f_x − golden|.
- `mean_err` out W: `sum_err >> LOG2_N`, floor.
- `max_err` out W: largest |f_x − golden|.
- `max_idx` out LOG2_N: batch index of first occurrence of `max_err`.
- `mse` out 2W: Σe² >> LOG2_N (macro only).
- `var_err` out 2W: `mse − mean_err²`, saturated at 0 (macro only).

## Operation
- States: IDLE, ACCUM, FINAL, DONE. Reset → IDLE.
- IDLE: `start` → ACCUM; accumulators, sample counter and pipeline valid are cleared.
- ACCUM: each accepted sample gets index `cnt`, and `cnt` increments. Stage 1 registers `e = |f_x − golden|` from a 14-bit signed difference, plus its index. Stage 2 adds `e` to `sum_err`, and to Σe² when the macro is on. If `e > max_err` (strict), stage 2 updates `max_err` and `max_idx`. Ties keep the earlier index.
- When sample N−1 is accepted, `in_ready` drops the next cycle → FINAL. The counter does not wrap into a new batch.
- FINAL: drains stage 1→2, then computes `mean_err` and, under the macro, `mse` and `var_err`. Results are registered → DONE.
- DONE: outputs hold. `start` → ACCUM with a full clear. Other inputs are ignored.
- `start` in ACCUM or FINAL is ignored. `in_valid` while `in_ready` is low is ignored, with no backpressure beyond `in_ready`.
- `reset_n` low at any time, including mid-batch, forces IDLE and zeros every output.
- Arithmetic is unsigned. Accumulators are sized so they never overflow for N samples.

## Timing
- Reset values: `in_ready`, `busy`, `done` = 0; all result outputs = 0.
- `start` at edge t → `in_ready`, `busy` = 1 from t+1.
- Accepted sample at edge t → visible in accumulators at t+2.
- Last accepted sample at edge t → FINAL at t+1, DONE (`done` = 1, results valid) at t+3 (t+4 with macro, one extra cycle for the squaring/subtract).
- Throughput: one sample per cycle. Full batch = N + 3 cycles from first accept (N + 4 with macro).

## Configuration
- `SIGMOID_ERR_SQ_EN` defined: squared-error accumulator (2W+LOG2_N bits), `mse` and `var_err` are built. FINAL takes 2 cycles.
- Undefined: no squaring logic. `mse`/`var_err` are tied to 0. FINAL takes 1 cycle.

## Structure
- Package `sigmoid_pkg`: `W`, `LOG2_N` defaults, the `fx_u1_12_t` typedef and the `err_state_e` enum.
- One sub-module, `sigmoid_abs_diff`: registered |a − b| for W-bit unsigned inputs. This is stage 1.

## Test plan
- Reset: hold `reset_n` = 0 → all outputs 0, `in_ready` = 0. Release, then `start` → `in_ready` = 1 next cycle.
- LOG2_N = 2, samples (f_x, golden) = (0x800,0x800), (0x810,0x800), (0x7F0,0x800), (0x805,0x800) → `sum_err` = 0x25, `mean_err` = 0x9, `max_err` = 0x10, `max_idx` = 1 (tie with sample 2 keeps 1), `done` 3 cycles after last accept.
- Same batch with macro → `mse` = (0+256+256+25)>>2 = 134, `var_err` = 134 − 81 = 53.
- `in_valid` toggling 1/0 every cycle plus `start` pulses mid-batch → identical results to the contiguous run, and the start pulses are ignored.
- Full 4096-sample sweep with `f_x` = `golden` → all results 0, `done` after exactly 4096 accepts. A 4097th `in_valid` is not accepted.
- Assert `reset_n` low at sample 100 and release → IDLE, outputs 0. A new `start` yields a clean batch.
